jstk_poller: RTL and testbench

Polling controller that shares the 40-bit SPI master between the two player joystick PMODs (PmodJSTK) in the Pong design. It periodically starts a transfer to each joystick in turn, routes the master's chip-select to the selected device, and sends that player's LED command. It then unpacks the 5 returned bytes into registered X/Y/button outputs for the game logic. A watchdog aborts transfers the master never completes.

---
 rtl/jstk_poller.sv | 236 +++++++++++++++++++++++
 tb/tb_jstk_poller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poller.sv
`timescale 1ns / 1ps
// jstk_poller
//
// Shares one 40-bit SPI master between the two PmodJSTK joysticks of the Pong
// design. After an idle gap it triggers a transfer to one joystick, routes the
// master's chip-select to that device, sends the player's LED command and
// unpacks the returned bytes into registered X/Y/button outputs. Slots alternate
// 0,1,0,1 after every completed or aborted transfer. A watchdog aborts transfers
// the master never finishes.
//
// Ports
//   clk            50 MHz clock, all state on its rising edge
//   rst_n          asynchronous active-low reset
//   enable         polling allowed; low blocks new transfers
//   led1, led2     LED command bits for joystick 1 / joystick 2
//   spi_trigger    transfer request to the SPI master
//   spi_out_bytes  command word for the SPI master
//   spi_cs         master's active-low chip-select (asynchronous to clk)
//   spi_in_bytes   bytes received by the master, first byte in [39:32]
//   jstk_cs_n      per-joystick chip-selects, active low, bit 0 = player 1
//   p1_*, p2_*     unpacked position/buttons per player
//   p1_valid, p2_valid  one-cycle pulse on capture
//   timeout_err    sticky abort flag per slot

module jstk_poller #(
    parameter int POLL_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  led1,
    input  logic [1:0]  led2,
    output logic        spi_trigger,
    output logic [39:0] spi_out_bytes,
    input  logic        spi_cs,
    input  logic [39:0] spi_in_bytes,
    output logic [1:0]  jstk_cs_n,
    output logic [9:0]  p1_x,
    output logic [9:0]  p1_y,
    output logic [2:0]  p1_btn,
    output logic [9:0]  p2_x,
    output logic [9:0]  p2_y,
    output logic [2:0]  p2_btn,
    output logic        p1_valid,
    output logic        p2_valid,
    output logic [1:0]  timeout_err
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [POLL_W-1:0] POLL_TC = POLL_W'(POLL_CYCLES - 1);
    localparam logic [15:0] TO_TC = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StArm  = 2'd1;
    localparam logic [1:0] StBusy = 2'd2;

    localparam logic [9:0] CENTER = 10'd512;

    logic              cs_meta, cs_s;
    logic [1:0]        state_q, state_d;
    logic              slot_q;
    logic [POLL_W-1:0] poll_ctr_q, poll_ctr_d;
    logic [15:0]       to_ctr_q;
    logic              trigger_q;
    logic [39:0]       out_bytes_q;
    logic [9:0]        p1_x_q, p1_y_q, p2_x_q, p2_y_q;
    logic [2:0]        p1_btn_q, p2_btn_q;
    logic              p1_valid_q, p2_valid_q;
    logic [1:0]        err_q;

    logic start, go_busy, done, abort;
    logic poll_tc, to_tc, in_xfer;

    logic [9:0] rx_x, rx_y;
    logic [2:0] rx_btn;
    logic       unused_in;

    // Byte layout from the PmodJSTK: X low, X high, Y low, Y high, buttons.
    assign rx_x      = {spi_in_bytes[25:24], spi_in_bytes[39:32]};
    assign rx_y      = {spi_in_bytes[9:8], spi_in_bytes[23:16]};
    assign rx_btn    = spi_in_bytes[2:0];
    assign unused_in = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};

    // Synchronizer resets to "master idle" so a busy master after reset is only
    // seen once the real level has propagated through both flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
        end else begin
            cs_meta <= spi_cs;
            cs_s    <= cs_meta;
        end
    end

    assign poll_tc = (poll_ctr_q == POLL_TC);
    assign to_tc   = (to_ctr_q == TO_TC);
    assign in_xfer = (state_q == StArm) || (state_q == StBusy);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        go_busy = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && poll_tc && cs_s) begin
                    start   = 1'b1;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (to_tc) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (!cs_s) begin
                    go_busy = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A completion seen on the watchdog's last cycle still counts.
                if (cs_s) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (to_tc) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Poll counter holds at terminal count while the master is still busy.
    always_comb begin
        poll_ctr_d = poll_ctr_q;
        if (state_q != StIdle || !enable || start) begin
            poll_ctr_d = '0;
        end else if (!poll_tc) begin
            poll_ctr_d = poll_ctr_q + POLL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            slot_q      <= 1'b0;
            poll_ctr_q  <= '0;
            to_ctr_q    <= '0;
            trigger_q   <= 1'b0;
            out_bytes_q <= '0;
        end else begin
            state_q    <= state_d;
            poll_ctr_q <= poll_ctr_d;

            if (start) begin
                to_ctr_q <= '0;
            end else if (in_xfer) begin
                to_ctr_q <= to_ctr_q + 16'd1;
            end

            if (start) begin
                trigger_q <= 1'b1;
            end else if (go_busy || abort) begin
                trigger_q <= 1'b0;
            end

            if (start) begin
                out_bytes_q <= {6'b100000, (slot_q ? led2 : led1), 32'h0};
            end

            if (done || abort) begin
                slot_q <= ~slot_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_x_q     <= CENTER;
            p1_y_q     <= CENTER;
            p1_btn_q   <= '0;
            p2_x_q     <= CENTER;
            p2_y_q     <= CENTER;
            p2_btn_q   <= '0;
            p1_valid_q <= 1'b0;
            p2_valid_q <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            p1_valid_q <= done && !slot_q;
            p2_valid_q <= done && slot_q;

            if (done && !slot_q) begin
                p1_x_q   <= rx_x;
                p1_y_q   <= rx_y;
                p1_btn_q <= rx_btn;
            end
            if (done && slot_q) begin
                p2_x_q   <= rx_x;
                p2_y_q   <= rx_y;
                p2_btn_q <= rx_btn;
            end

            if (abort) begin
                err_q[slot_q] <= 1'b1;
            end else if (done) begin
                err_q[slot_q] <= 1'b0;
            end
        end
    end

    // Raw chip-select is routed combinationally so the joystick sees the
    // master's own timing; idle and reset keep both devices deselected.
    always_comb begin
        jstk_cs_n = 2'b11;
        if (in_xfer) begin
            jstk_cs_n[slot_q] = spi_cs;
        end
    end

    assign spi_trigger   = trigger_q;
    assign spi_out_bytes = out_bytes_q;
    assign p1_x          = p1_x_q;
    assign p1_y          = p1_y_q;
    assign p1_btn        = p1_btn_q;
    assign p2_x          = p2_x_q;
    assign p2_y          = p2_y_q;
    assign p2_btn        = p2_btn_q;
    assign p1_valid      = p1_valid_q;
    assign p2_valid      = p2_valid_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_jstk_poller.sv
`timescale 1ns / 1ps
// Directed bench for jstk_poller with a behavioural SPI master/slave model.

module tb_jstk_poller;

    localparam int P = 100;
    localparam int T = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  led1 = 2'b01;
    logic [1:0]  led2 = 2'b10;
    logic        spi_cs = 1'b1;
    logic [39:0] spi_in_bytes = '0;
    logic        spi_trigger;
    logic [39:0] spi_out_bytes;
    logic [1:0]  jstk_cs_n;
    logic [9:0]  p1_x, p1_y, p2_x, p2_y;
    logic [2:0]  p1_btn, p2_btn;
    logic        p1_valid, p2_valid;
    logic [1:0]  timeout_err;

    int checks = 0;
    int errors = 0;

    // 0: normal transfer, 1: master never starts, 2: hold spi_cs low until released
    int          model_mode = 0;
    logic [39:0] model_data = '0;

    jstk_poller #(
        .POLL_CYCLES   (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .led1         (led1),
        .led2         (led2),
        .spi_trigger  (spi_trigger),
        .spi_out_bytes(spi_out_bytes),
        .spi_cs       (spi_cs),
        .spi_in_bytes (spi_in_bytes),
        .jstk_cs_n    (jstk_cs_n),
        .p1_x         (p1_x),
        .p1_y         (p1_y),
        .p1_btn       (p1_btn),
        .p2_x         (p2_x),
        .p2_y         (p2_y),
        .p2_btn       (p2_btn),
        .p1_valid     (p1_valid),
        .p2_valid     (p2_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (spi_trigger === 1'b1 && model_mode != 1) begin
                repeat (4) @(negedge clk);
                spi_cs = 1'b0;
                if (model_mode == 2) wait (model_mode != 2);
                else repeat (30) @(negedge clk);
                spi_in_bytes = model_data;
                spi_cs = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

    task automatic wait_trig(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (spi_trigger === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_cs_low(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (spi_cs === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 1 && p1_valid === 1'b1) || (which == 2 && p2_valid === 1'b1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        enable = 1'b1;
        model_data = 40'h2C_01_F0_03_05;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (spi_trigger !== 1'b0) begin
            errors++; $display("FAIL reset_trigger: got %b want 0", spi_trigger);
        end
        checks++;
        if (spi_out_bytes !== 40'h0) begin
            errors++; $display("FAIL reset_out_bytes: got %h want 0", spi_out_bytes);
        end
        checks++;
        if (jstk_cs_n !== 2'b11) begin
            errors++; $display("FAIL reset_cs_n: got %b want 11", jstk_cs_n);
        end
        checks++;
        if ({p1_x, p1_y, p1_btn, p2_x, p2_y, p2_btn} !==
            {10'd512, 10'd512, 3'd0, 10'd512, 10'd512, 3'd0}) begin
            errors++;
            $display("FAIL reset_pos: got %0d %0d %0d %0d %0d %0d want 512 512 0 512 512 0",
                     p1_x, p1_y, p1_btn, p2_x, p2_y, p2_btn);
        end
        checks++;
        if ({p1_valid, p2_valid, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b want 0000", p1_valid, p2_valid, timeout_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_trig(P + 20, n);
        checks++;
        if (n != P) begin
            errors++; $display("FAIL reset_first_trigger: got %0d cycles want %0d", n, P);
        end
    endtask

    task automatic test_slot0();
        int n, g, pulses;
        checks++;
        if (spi_out_bytes !== 40'h81_0000_0000) begin
            errors++; $display("FAIL s0_out_bytes: got %h want 8100000000", spi_out_bytes);
        end
        wait_cs_low(20, n);
        repeat (5) @(negedge clk);
        checks++;
        if (jstk_cs_n !== 2'b10 || spi_cs !== 1'b0) begin
            errors++; $display("FAIL s0_cs_n: got %b (spi_cs %b) want 10", jstk_cs_n, spi_cs);
        end
        checks++;
        if (spi_trigger !== 1'b0 || spi_out_bytes !== 40'h81_0000_0000) begin
            errors++;
            $display("FAIL s0_busy: got trigger %b bytes %h want 0 8100000000",
                     spi_trigger, spi_out_bytes);
        end
        wait_valid(1, 60, n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL s0_valid: got no p1_valid want one pulse");
        end
        checks++;
        if (p1_x !== 10'd300 || p1_y !== 10'd1008 || p1_btn !== 3'b101) begin
            errors++;
            $display("FAIL s0_data: got %0d %0d %b want 300 1008 101", p1_x, p1_y, p1_btn);
        end
        checks++;
        if (p2_x !== 10'd512 || p2_y !== 10'd512 || p2_btn !== 3'd0) begin
            errors++;
            $display("FAIL s0_p2_hold: got %0d %0d %b want 512 512 000", p2_x, p2_y, p2_btn);
        end
        model_data = 40'hFF_03_00_00_02;
        g = 0;
        pulses = 0;
        for (int i = 0; i < P + 20; i++) begin
            @(negedge clk);
            g++;
            if (p1_valid === 1'b1 || p2_valid === 1'b1) pulses++;
            if (spi_trigger === 1'b1) break;
        end
        checks++;
        if (g != P) begin
            errors++; $display("FAIL s0_gap: got %0d cycles want %0d", g, P);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL s0_valid_width: got %0d extra valid cycles want 0", pulses);
        end
    endtask

    task automatic test_alternation();
        int n;
        checks++;
        if (spi_out_bytes !== 40'h82_0000_0000) begin
            errors++; $display("FAIL alt_out_bytes: got %h want 8200000000", spi_out_bytes);
        end
        wait_cs_low(20, n);
        repeat (5) @(negedge clk);
        checks++;
        if (jstk_cs_n !== 2'b01) begin
            errors++; $display("FAIL alt_cs_n: got %b want 01", jstk_cs_n);
        end
        wait_valid(2, 60, n);
        checks++;
        if (n < 0 || p2_x !== 10'd1023 || p2_y !== 10'd0 || p2_btn !== 3'b010) begin
            errors++;
            $display("FAIL alt_data: got n=%0d %0d %0d %b want 1023 0 010", n, p2_x, p2_y, p2_btn);
        end
        checks++;
        if (p1_x !== 10'd300 || p1_y !== 10'd1008 || p1_btn !== 3'b101) begin
            errors++;
            $display("FAIL alt_p1_hold: got %0d %0d %b want 300 1008 101", p1_x, p1_y, p1_btn);
        end
        model_mode = 1;
    endtask

    task automatic test_timeout();
        int n, hi, pulses;
        wait_trig(P + 20, n);
        hi = (n > 0) ? 1 : 0;
        pulses = 0;
        for (int i = 0; i < T + 20; i++) begin
            @(negedge clk);
            if (p1_valid === 1'b1) pulses++;
            if (spi_trigger === 1'b1) hi++;
            else break;
        end
        checks++;
        if (hi != T) begin
            errors++; $display("FAIL to_trigger_len: got %0d cycles want %0d", hi, T);
        end
        checks++;
        if (timeout_err !== 2'b01 || pulses != 0) begin
            errors++;
            $display("FAIL to_err: got err %b valid %0d want 01 0", timeout_err, pulses);
        end
        checks++;
        if (p1_x !== 10'd300 || p1_y !== 10'd1008 || p1_btn !== 3'b101) begin
            errors++;
            $display("FAIL to_p1_hold: got %0d %0d %b want 300 1008 101", p1_x, p1_y, p1_btn);
        end
        model_mode = 0;
        model_data = 40'h10_02_20_01_07;
        wait_trig(P + 20, n);
        checks++;
        if (n < 0 || spi_out_bytes !== 40'h82_0000_0000) begin
            errors++; $display("FAIL to_next_slot: got n=%0d %h want 8200000000", n, spi_out_bytes);
        end
        wait_valid(2, 80, n);
        checks++;
        if (n < 0 || p2_x !== 10'd528 || p2_y !== 10'd288 || p2_btn !== 3'b111 ||
            timeout_err !== 2'b01) begin
            errors++;
            $display("FAIL to_s1_data: got n=%0d %0d %0d %b err %b want 528 288 111 01",
                     n, p2_x, p2_y, p2_btn, timeout_err);
        end
        model_data = 40'h7F_02_40_01_03;
        wait_trig(P + 20, n);
        wait_valid(1, 80, n);
        checks++;
        if (n < 0 || p1_x !== 10'd639 || p1_y !== 10'd320 || p1_btn !== 3'b011) begin
            errors++;
            $display("FAIL to_s0_data: got n=%0d %0d %0d %b want 639 320 011",
                     n, p1_x, p1_y, p1_btn);
        end
        checks++;
        if (timeout_err !== 2'b00) begin
            errors++; $display("FAIL to_clear: got %b want 00", timeout_err);
        end
    endtask

    task automatic test_enable();
        int n, hi;
        enable = 1'b0;
        hi = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (spi_trigger !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++; $display("FAIL en_gate: got %0d trigger cycles want 0", hi);
        end
        model_data = 40'h55_01_AA_02_04;
        enable = 1'b1;
        wait_trig(P + 20, n);
        checks++;
        if (n != P) begin
            errors++; $display("FAIL en_first_trigger: got %0d cycles want %0d", n, P);
        end
        wait_cs_low(20, n);
        enable = 1'b0;
        wait_valid(2, 80, n);
        checks++;
        if (n < 0 || p2_x !== 10'd341 || p2_y !== 10'd682 || p2_btn !== 3'b100) begin
            errors++;
            $display("FAIL en_mid_xfer: got n=%0d %0d %0d %b want 341 682 100",
                     n, p2_x, p2_y, p2_btn);
        end
        enable = 1'b1;
        model_mode = 2;
    endtask

    task automatic test_reset_busy();
        int n, bad, pulses;
        wait_trig(P + 20, n);
        wait_cs_low(20, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (jstk_cs_n !== 2'b11 || spi_trigger !== 1'b0 || p1_x !== 10'd512) begin
            errors++;
            $display("FAIL rb_reset: got cs_n %b trig %b p1_x %0d want 11 0 512",
                     jstk_cs_n, spi_trigger, p1_x);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (jstk_cs_n !== 2'b11 || spi_trigger !== 1'b0) bad++;
            if (p1_valid === 1'b1 || p2_valid === 1'b1) pulses++;
        end
        checks++;
        if (bad != 0 || pulses != 0) begin
            errors++;
            $display("FAIL rb_hold: got %0d bad cycles %0d valids want 0 0", bad, pulses);
        end
        model_mode = 0;
        n = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (spi_trigger === 1'b1 && n < 0) n = i;
        end
        checks++;
        if (n < 3 || n > 4) begin
            errors++; $display("FAIL rb_release: got trigger at %0d cycles want 3..4", n);
        end
    endtask

    initial begin
        test_reset();
        test_slot0();
        test_alternation();
        test_timeout();
        test_enable();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
